// File: rtl/sdram_aref.sv
// SDRAM auto-refresh generator: requests a refresh slot every interval, then issues
// PRECHARGE-ALL followed by REF_NUM AUTO REFRESH commands with tRP/tRFC spacing.
module sdram_aref #(
  parameter int CNT_REF_MAX = 749,
  parameter int TRP_CLK     = 2,
  parameter int TRFC_CLK    = 7,
  parameter int REF_NUM     = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_end,
  input  logic        aref_en,
  output logic        aref_req,
  output logic        aref_end,
  output logic [3:0]  aref_cmd,
  output logic [1:0]  aref_ba,
  output logic [12:0] aref_addr
);

  localparam int RCW     = (CNT_REF_MAX > 0) ? $clog2(CNT_REF_MAX + 1) : 1;
  localparam int CLK_MAX = (TRP_CLK > TRFC_CLK) ? TRP_CLK : TRFC_CLK;
  localparam int CCW     = (CLK_MAX > 1) ? $clog2(CLK_MAX + 1) : 1;
  localparam int NCW     = $clog2(REF_NUM + 1);

  localparam logic [RCW-1:0] REF_LAST  = RCW'(CNT_REF_MAX);
  localparam logic [CCW-1:0] TRP_LAST  = CCW'(TRP_CLK - 1);
  localparam logic [CCW-1:0] TRFC_LAST = CCW'(TRFC_CLK - 1);
  localparam logic [NCW-1:0] REF_TOTAL = NCW'(REF_NUM);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PCHG = 3'd1;
  localparam logic [2:0] S_TRP  = 3'd2;
  localparam logic [2:0] S_AREF = 3'd3;
  localparam logic [2:0] S_TRFC = 3'd4;
  localparam logic [2:0] S_END  = 3'd5;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PCHG = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  logic [2:0]     state_q, state_d;
  logic [RCW-1:0] ref_cnt_q, ref_cnt_d;
  logic [CCW-1:0] clk_cnt_q, clk_cnt_d;
  logic [NCW-1:0] ref_num_cnt_q, ref_num_cnt_d;
  logic           aref_req_q, aref_req_d;
  logic           grant;

  assign grant = (state_q == S_IDLE) && aref_en;

  always_comb begin
    ref_cnt_d  = ref_cnt_q;
    aref_req_d = aref_req_q;
    if (!init_end) begin
      ref_cnt_d = '0;
    end else if (ref_cnt_q == REF_LAST) begin
      ref_cnt_d = '0;
    end else begin
      ref_cnt_d = ref_cnt_q + RCW'(1);
    end
    // An interval elapsing on the grant edge wins, so no request is ever lost mid-sequence.
    if (!init_end) begin
      aref_req_d = 1'b0;
    end else if (ref_cnt_q == REF_LAST) begin
      aref_req_d = 1'b1;
    end else if (grant) begin
      aref_req_d = 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    clk_cnt_d     = clk_cnt_q;
    ref_num_cnt_d = ref_num_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (aref_en) state_d = S_PCHG;
      end
      S_PCHG: begin
        state_d   = S_TRP;
        clk_cnt_d = '0;
      end
      S_TRP: begin
        if (clk_cnt_q == TRP_LAST) begin
          clk_cnt_d = '0;
          state_d   = S_AREF;
        end else begin
          clk_cnt_d = clk_cnt_q + CCW'(1);
        end
      end
      S_AREF: begin
        state_d       = S_TRFC;
        clk_cnt_d     = '0;
        ref_num_cnt_d = ref_num_cnt_q + NCW'(1);
      end
      S_TRFC: begin
        if (clk_cnt_q == TRFC_LAST) begin
          clk_cnt_d = '0;
          state_d   = (ref_num_cnt_q < REF_TOTAL) ? S_AREF : S_END;
        end else begin
          clk_cnt_d = clk_cnt_q + CCW'(1);
        end
      end
      S_END: begin
        state_d       = S_IDLE;
        ref_num_cnt_d = '0;
      end
      default: begin
        state_d       = S_IDLE;
        clk_cnt_d     = '0;
        ref_num_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= S_IDLE;
      ref_cnt_q     <= '0;
      clk_cnt_q     <= '0;
      ref_num_cnt_q <= '0;
      aref_req_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ref_cnt_q     <= ref_cnt_d;
      clk_cnt_q     <= clk_cnt_d;
      ref_num_cnt_q <= ref_num_cnt_d;
      aref_req_q    <= aref_req_d;
    end
  end

  // Command is a pure state decode so reset forces NOP without waiting for a clock.
  always_comb begin
    case (state_q)
      S_PCHG:  aref_cmd = CMD_PCHG;
      S_AREF:  aref_cmd = CMD_AREF;
      default: aref_cmd = CMD_NOP;
    endcase
  end

  assign aref_req  = aref_req_q;
  assign aref_end  = (state_q == S_END);
  assign aref_ba   = 2'b11;
  assign aref_addr = 13'h1fff;

endmodule
